bcd_conv_arbiter: RTL and testbench
===================================

Name: bcd_conv_arbiter

Overview:
Shares a single binary-to-BCD double-dabble converter between NUM_REQ requesters using round-robin arbitration. The block sequences the converter's Start/DV handshake and returns the result to the granted requester. A watchdog aborts conversions that never complete. It sits between the converter instance and the display and UART formatting clients at the top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
INPUT_WIDTH, 8, binary operand width per requester
DECIMAL_DIGITS, 3, BCD digits produced by the converter
TIMEOUT_CYCLES, 64, cycles allowed in WAIT before abort (must exceed converter latency)

Ports:
i_Clock  in  1  system clock
i_Rst_L  in  1  asynchronous active-low reset
i_Req  in  NUM_REQ  per-requester request; held high until o_Ack or o_Err
i_Binary  in  NUM_REQ*INPUT_WIDTH  packed operands; requester r at bits [r*INPUT_WIDTH +: INPUT_WIDTH]
o_Ack  out  NUM_REQ  one-hot, 1-cycle pulse: result valid on o_BCD for that requester
o_Err  out  NUM_REQ  one-hot, 1-cycle pulse: conversion timed out
o_BCD  out  DECIMAL_DIGITS*4  last converted result, held until next success
o_Busy  out  1  high in any state other than IDLE
o_Conv_Start  out  1  start pulse to converter
o_Conv_Binary  out  INPUT_WIDTH  operand to converter, stable from START until the next grant
i_Conv_BCD  in  DECIMAL_DIGITS*4  converter result
i_Conv_DV  in  1  converter result-valid pulse

Behaviour:
- Clock and reset: single clock. Reset is asynchronous, active-low on i_Rst_L.
- Reset values: state IDLE, all outputs 0, rr pointer 0, timer 0, latched index 0.
- States: IDLE -> START -> WAIT -> DONE | FAIL -> IDLE. All outputs are registered.
- IDLE:
  - When any i_Req bit is set, grant the first set bit at or above the pointer, wrapping modulo NUM_REQ.
  - Latch the grant index and that requester's operand into o_Conv_Binary, then go to START.
- START:
  - o_Conv_Start high for exactly this cycle.
  - Timer cleared. Go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - If i_Conv_DV is high: o_BCD <= i_Conv_BCD, go to DONE.
  - Otherwise, if timer == TIMEOUT_CYCLES-1: go to FAIL. o_BCD is unchanged.
- DONE: o_Ack[idx] = 1 for this cycle only. Pointer <= (idx+1) mod NUM_REQ. Go to IDLE.
- FAIL: o_Err[idx] = 1 for this cycle only. Pointer <= (idx+1) mod NUM_REQ. Go to IDLE.
- Requester rule: drop i_Req on the edge ending the ack/err cycle. IDLE therefore never re-grants the same transaction.
- Latency:
  - Request sampled at edge k (IDLE) -> Start high in cycle k+1.
  - DV seen at edge d -> o_Ack high in cycle d+1.
  - Minimum back-to-back grant spacing is ack cycle + 1 IDLE cycle.
- Request withdrawn after grant: the conversion completes and Ack/Err still pulses; the requester ignores it.
- Request withdrawn before grant: the requester is not served.
- i_Conv_DV outside WAIT (late DV after timeout, or spurious) is ignored. o_BCD is not updated.
- Request bits for indices >= NUM_REQ do not exist. Pointer wrap: NUM_REQ-1 -> 0.
- Simultaneous requests: exactly one grant per transaction. Over consecutive transactions with all requests held, the grant order is strictly rotating.
- Reset mid-operation: returns to IDLE immediately. Any in-flight Ack/Err is lost, and o_Conv_Start is forced low.

Decomposition:
- Package bcd_arb_pkg holds:
  - the state enum (IDLE, START, WAIT, DONE, FAIL);
  - the timer width constant, $clog2(TIMEOUT_CYCLES);
  - the index width helper.
- One combinational sub-module, rr_pick: given the request vector and pointer, it returns the valid flag and grant index.
- The converter is instantiated beside this block at top level, not inside it.

Test Plan:
- Single request: req0 with operand 8'h0C, real converter -> one Start pulse, o_Ack=4'b0001, o_BCD=12'h012; o_Busy low afterwards.
- Max value: req2 with operand 8'hFF -> o_BCD=12'h255, o_Ack=4'b0100, pointer=3.
- Contention: req=4'b1111 held, operands 1,2,3,4 -> acks in order 0,1,2,3, then wrap to 0; BCD results 001, 002, 003, 004.
- Timeout: stub converter never asserts DV, req1 -> o_Err=4'b0010 exactly TIMEOUT_CYCLES+1 cycles after Start; o_BCD unchanged. A late DV afterwards is ignored.
- Reset in WAIT: assert i_Rst_L=0 during a conversion -> all outputs 0 asynchronously, state IDLE; a fresh request is then served normally from pointer 0.
- Withdrawn request: req3 raised and dropped before grant while req0 is being served -> req3 gets no Ack or Err.

Source files
------------

// File: rtl/bcd_arb_pkg.sv
// Shared types and width helpers for the BCD converter arbiter.
package bcd_arb_pkg;

    // Arbiter sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAIL  = 3'd4
    } arb_state_e;

    // Default timeout; the timer width is derived from it.
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;
    localparam int DEFAULT_TIMER_W        = $clog2(DEFAULT_TIMEOUT_CYCLES);

    // Bits needed to hold an index 0..n-1 (at least one bit).
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    // Bits needed for a timer that counts 0..timeout_cycles-1.
    function automatic int timer_width(input int timeout_cycles);
        return idx_width(timeout_cycles);
    endfunction

endpackage

// File: rtl/bcd_conv_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NUM_REQ.
module rr_pick
    import bcd_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    int cand_s;

    // Scan requests starting at the pointer; the first hit wins.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        cand_s = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = (int'(ptr) + i) % NUM_REQ;
            if (!valid && req[IDX_W'(cand_s)]) begin
                valid = 1'b1;
                idx   = IDX_W'(cand_s);
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD converter between
// NUM_REQ requesters, with a watchdog that aborts stuck conversions.
module bcd_conv_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int INPUT_WIDTH    = 8,
    parameter int DECIMAL_DIGITS = 3,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_L,
    input  logic [NUM_REQ-1:0]            i_Req,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] i_Binary,
    output logic [NUM_REQ-1:0]            o_Ack,
    output logic [NUM_REQ-1:0]            o_Err,
    output logic [DECIMAL_DIGITS*4-1:0]   o_BCD,
    output logic                          o_Busy,
    output logic                          o_Conv_Start,
    output logic [INPUT_WIDTH-1:0]        o_Conv_Binary,
    input  logic [DECIMAL_DIGITS*4-1:0]   i_Conv_BCD,
    input  logic                          i_Conv_DV
);

    localparam int IDX_W   = idx_width(NUM_REQ);
    localparam int TIMER_W = timer_width(TIMEOUT_CYCLES);
    localparam logic [NUM_REQ-1:0] ONE_HOT_BASE = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]   LAST_IDX     = IDX_W'(NUM_REQ - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST   = TIMER_W'(TIMEOUT_CYCLES - 1);

    arb_state_e                  state_r, state_s;
    logic [IDX_W-1:0]            ptr_r, ptr_s;
    logic [IDX_W-1:0]            idx_r, idx_s;
    logic [TIMER_W-1:0]          timer_r, timer_s;
    logic [INPUT_WIDTH-1:0]      conv_binary_r, conv_binary_s;
    logic [DECIMAL_DIGITS*4-1:0] bcd_r, bcd_s;
    logic [NUM_REQ-1:0]          ack_r, ack_s;
    logic [NUM_REQ-1:0]          err_r, err_s;
    logic                        start_r, start_s;
    logic                        busy_r, busy_s;

    logic                        pick_valid_s;
    logic [IDX_W-1:0]            pick_idx_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (i_Req),
        .ptr   (ptr_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_s       = state_r;
        ptr_s         = ptr_r;
        idx_s         = idx_r;
        timer_s       = timer_r;
        conv_binary_s = conv_binary_r;
        bcd_s         = bcd_r;
        ack_s         = '0;
        err_s         = '0;
        start_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    idx_s         = pick_idx_s;
                    conv_binary_s = i_Binary[pick_idx_s*INPUT_WIDTH +: INPUT_WIDTH];
                    start_s       = 1'b1;
                    state_s       = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                timer_s = '0;
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                timer_s = timer_r + TIMER_W'(1);
                // A valid result takes priority over a same-cycle timeout.
                if (i_Conv_DV) begin
                    bcd_s   = i_Conv_BCD;
                    ack_s   = ONE_HOT_BASE << idx_r;
                    state_s = ST_DONE;
                end else if (timer_r == TIMER_LAST) begin
                    err_s   = ONE_HOT_BASE << idx_r;
                    state_s = ST_FAIL;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE, ST_FAIL: begin
                if (idx_r == LAST_IDX) begin
                    ptr_s = '0;
                end else begin
                    ptr_s = idx_r + IDX_W'(1);
                end
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers; async reset clears everything, including
    // any pending pulse.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_r       <= ST_IDLE;
            ptr_r         <= '0;
            idx_r         <= '0;
            timer_r       <= '0;
            conv_binary_r <= '0;
            bcd_r         <= '0;
            ack_r         <= '0;
            err_r         <= '0;
            start_r       <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            ptr_r         <= ptr_s;
            idx_r         <= idx_s;
            timer_r       <= timer_s;
            conv_binary_r <= conv_binary_s;
            bcd_r         <= bcd_s;
            ack_r         <= ack_s;
            err_r         <= err_s;
            start_r       <= start_s;
            busy_r        <= busy_s;
        end
    end

    assign o_Ack         = ack_r;
    assign o_Err         = err_r;
    assign o_BCD         = bcd_r;
    assign o_Busy        = busy_r;
    assign o_Conv_Start  = start_r;
    assign o_Conv_Binary = conv_binary_r;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed, table-driven bench for bcd_conv_arbiter with a behavioural
// multi-cycle converter model beside the DUT.
module tb_bcd_conv_arbiter;

    localparam int NR  = 4;
    localparam int IW  = 8;
    localparam int DD  = 3;
    localparam int TO  = 64;
    localparam int LAT = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req;
    logic [NR*IW-1:0] bin;
    logic [NR-1:0] o_ack, o_err;
    logic [11:0]   o_bcd;
    logic          o_busy, o_start;
    logic [7:0]    o_cbin;
    logic [11:0]   conv_bcd;
    logic          conv_dv;

    logic          model_en;
    logic          model_dv;
    logic [11:0]   model_bcd;
    logic [7:0]    model_val;
    int            model_lat;
    logic          force_dv;
    logic [11:0]   force_bcd;

    int            cyc = 0;
    int            n_starts = 0;
    int            start_cyc = 0;
    int            n_cmp = 0;
    int            n_fail = 0;

    typedef struct {
        int         r;
        logic [7:0] op;
        logic [3:0] ack;
        logic [11:0] bcd;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    assign conv_dv  = model_dv | force_dv;
    assign conv_bcd = force_dv ? force_bcd : model_bcd;

    bcd_conv_arbiter #(
        .NUM_REQ(NR), .INPUT_WIDTH(IW), .DECIMAL_DIGITS(DD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Req(req), .i_Binary(bin),
        .o_Ack(o_ack), .o_Err(o_err), .o_BCD(o_bcd), .o_Busy(o_busy),
        .o_Conv_Start(o_start), .o_Conv_Binary(o_cbin),
        .i_Conv_BCD(conv_bcd), .i_Conv_DV(conv_dv)
    );

    function automatic logic [11:0] to_bcd(input logic [7:0] v);
        int x;
        x = int'(v);
        return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    // Behavioural converter: result valid LAT cycles after the start pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_dv  <= 1'b0;
            model_bcd <= 12'h000;
            model_val <= 8'h00;
            model_lat <= 0;
        end else begin
            model_dv <= 1'b0;
            if (o_start) begin
                model_val <= o_cbin;
                model_lat <= LAT;
            end else if (model_lat != 0) begin
                model_lat <= model_lat - 1;
                if (model_lat == 1) begin
                    model_dv  <= model_en;
                    model_bcd <= to_bcd(model_val);
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_start) begin
            n_starts  <= n_starts + 1;
            start_cyc <= cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output logic [3:0] ack, output logic [3:0] err, output int at);
        logic seen;
        seen = 1'b0;
        ack  = 4'h0;
        err  = 4'h0;
        at   = 0;
        for (int i = 0; i < 300; i++) begin
            if (!seen) begin
                tick();
                if ((o_ack | o_err) != 4'h0) begin
                    seen = 1'b1;
                    ack  = o_ack;
                    err  = o_err;
                    at   = cyc;
                end
            end
        end
        if (!seen) check("wait_bound", 32'd0, 32'd1);
    endtask

    task automatic run_txn(input string name, input int r, input logic [7:0] op,
                           input logic [3:0] exp_ack, input logic [11:0] exp_bcd);
        logic [3:0] a, e;
        int at, s0;
        s0 = n_starts;
        req[r] = 1'b1;
        bin[r*IW +: IW] = op;
        wait_done(a, e, at);
        req[r] = 1'b0;
        check({name, "_ack"}, 32'(a), 32'(exp_ack));
        check({name, "_err"}, 32'(e), 32'd0);
        check({name, "_bcd"}, 32'(o_bcd), 32'(exp_bcd));
        tick();
        check({name, "_busy_after"}, 32'(o_busy), 32'd0);
        check({name, "_starts"}, 32'(n_starts - s0), 32'd1);
    endtask

    initial begin
        logic [3:0] a, e;
        int at, evt;
        logic [11:0] exp_seq [5];

        vecs[0] = '{0, 8'h0C, 4'b0001, 12'h012};
        vecs[1] = '{1, 8'h00, 4'b0010, 12'h000};
        vecs[2] = '{3, 8'h63, 4'b1000, 12'h099};
        vecs[3] = '{0, 8'h64, 4'b0001, 12'h100};
        vecs[4] = '{1, 8'h80, 4'b0010, 12'h128};
        vecs[5] = '{2, 8'hFF, 4'b0100, 12'h255};

        rst_n     = 1'b0;
        req       = 4'h0;
        bin       = 32'h0;
        model_en  = 1'b1;
        force_dv  = 1'b0;
        force_bcd = 12'h000;
        tick(); tick(); tick();
        check("rst_ack",   32'(o_ack),   32'd0);
        check("rst_err",   32'(o_err),   32'd0);
        check("rst_bcd",   32'(o_bcd),   32'd0);
        check("rst_busy",  32'(o_busy),  32'd0);
        check("rst_start", 32'(o_start), 32'd0);
        check("rst_cbin",  32'(o_cbin),  32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].r, vecs[i].op, vecs[i].ack, vecs[i].bcd);
        end

        // Pointer sits at 3 after serving requester 2: 3 beats 0.
        bin[0*IW +: IW] = 8'h2D;
        bin[3*IW +: IW] = 8'hC8;
        req = 4'b1001;
        wait_done(a, e, at);
        req[3] = 1'b0;
        check("ptr3_ack", 32'(a), 32'h8);
        check("ptr3_bcd", 32'(o_bcd), 32'h200);
        wait_done(a, e, at);
        req[0] = 1'b0;
        check("ptr_wrap_ack", 32'(a), 32'h1);
        check("ptr_wrap_bcd", 32'(o_bcd), 32'h045);
        tick();

        // Timeout with a silent converter, then a late DV.
        model_en = 1'b0;
        req[1] = 1'b1;
        bin[1*IW +: IW] = 8'h05;
        wait_done(a, e, at);
        req[1] = 1'b0;
        check("to_err", 32'(e), 32'h2);
        check("to_ack", 32'(a), 32'h0);
        check("to_latency", 32'(at - start_cyc), 32'(TO + 1));
        check("to_bcd_held", 32'(o_bcd), 32'h045);
        tick();
        force_bcd = 12'h999;
        force_dv  = 1'b1;
        tick();
        force_dv  = 1'b0;
        evt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if ((o_ack | o_err) != 4'h0) evt++;
        end
        check("late_dv_events", 32'(evt), 32'd0);
        check("late_dv_bcd", 32'(o_bcd), 32'h045);
        check("late_dv_busy", 32'(o_busy), 32'd0);
        model_en = 1'b1;

        // Reset during WAIT.
        req[2] = 1'b1;
        bin[2*IW +: IW] = 8'h2A;
        evt = 0;
        for (int i = 0; i < 20; i++) begin
            if (evt == 0) begin
                tick();
                if (o_start) evt = 1;
            end
        end
        check("rw_started", 32'(evt), 32'd1);
        tick(); tick(); tick();
        rst_n = 1'b0;
        req   = 4'h0;
        #1;
        check("rw_busy",  32'(o_busy),  32'd0);
        check("rw_bcd",   32'(o_bcd),   32'd0);
        check("rw_cbin",  32'(o_cbin),  32'd0);
        check("rw_start", 32'(o_start), 32'd0);
        check("rw_ackerr", 32'(o_ack | o_err), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Contention from pointer 0 with all requests held.
        bin = {8'd4, 8'd3, 8'd2, 8'd1};
        req = 4'b1111;
        exp_seq[0] = 12'h001; exp_seq[1] = 12'h002; exp_seq[2] = 12'h003;
        exp_seq[3] = 12'h004; exp_seq[4] = 12'h001;
        for (int k = 0; k < 5; k++) begin
            wait_done(a, e, at);
            if (k == 4) req = 4'h0;
            check($sformatf("cont%0d_ack", k), 32'(a), 32'(4'b0001 << (k % 4)));
            check($sformatf("cont%0d_bcd", k), 32'(o_bcd), 32'(exp_seq[k]));
        end
        tick();

        // Requester 3 withdraws before it can be granted.
        req[0] = 1'b1;
        bin[0*IW +: IW] = 8'h07;
        tick(); tick();
        req[3] = 1'b1;
        bin[3*IW +: IW] = 8'h09;
        tick(); tick();
        req[3] = 1'b0;
        wait_done(a, e, at);
        req[0] = 1'b0;
        check("wd_ack", 32'(a), 32'h1);
        check("wd_bcd", 32'(o_bcd), 32'h007);
        evt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if ((o_ack | o_err) != 4'h0) evt++;
        end
        check("wd_no_service", 32'(evt), 32'd0);
        check("wd_busy", 32'(o_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
